// File: rtl/nr_div_pkg.sv
// Shared definitions for the sequential non-restoring divider: FSM state
// encoding and the iteration counter sizing helper.
package nr_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        FIN  = 2'd3
    } state_t;

    // The counter has to reach N, so it needs clog2(N+1) bits.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/nr_div_step.sv
// One non-restoring iteration: shift in the next dividend bit, then add or
// subtract the divisor magnitude depending on the sign of the partial remainder.
module nr_div_step #(
    parameter int N = 8
) (
    input  logic [N:0]   accu,
    input  logic         dd_msb,
    input  logic [N-1:0] dr_mag,
    output logic [N:0]   accu_next,
    output logic         q_bit
);

    logic [N:0] accu_sh;
    logic [N:0] dr_ext;

    // The shifted value may wrap in N+1 bits; the result after the add or
    // subtract is always back in range, so modular arithmetic is exact.
    always_comb begin
        accu_sh   = {accu[N-1:0], dd_msb};
        dr_ext    = {1'b0, dr_mag};
        accu_next = accu[N] ? (accu_sh + dr_ext) : (accu_sh - dr_ext);
        q_bit     = ~accu_next[N];
    end

endmodule

// File: rtl/nr_div_seq.sv
// Sequential N-bit non-restoring divider with start/busy/done handshake,
// optional signed mode, divide-by-zero and signed-overflow flags.
module nr_div_seq
    import nr_div_pkg::*;
#(
    parameter int N         = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         signed_mode,
    input  logic [N-1:0] dd_in,
    input  logic [N-1:0] dr_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int           CW      = cnt_width(N);
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    state_t         state_q, state_d;
    logic [N:0]     accu_q, accu_d;
    logic [N-1:0]   dd_q, dd_d;
    logic [N-1:0]   dr_mag_q, dr_mag_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           q_neg_q, q_neg_d;
    logic           r_neg_q, r_neg_d;
    logic           dbz_pend_q, dbz_pend_d;
    logic           ovf_pend_q, ovf_pend_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [N-1:0]   quotient_q, quotient_d;
    logic [N-1:0]   remainder_q, remainder_d;
    logic           div_by_zero_q, div_by_zero_d;
    logic           overflow_q, overflow_d;

    logic           sgn;
    logic           dd_neg;
    logic           dr_neg;
    logic [N-1:0]   dd_mag;
    logic [N-1:0]   dr_mag;
    logic [N:0]     step_accu;
    logic           step_qbit;
    logic [N:0]     accu_rest;
    logic [N-1:0]   rem_mag;

    nr_div_step #(.N(N)) u_step (
        .accu      (accu_q),
        .dd_msb    (dd_q[N-1]),
        .dr_mag    (dr_mag_q),
        .accu_next (step_accu),
        .q_bit     (step_qbit)
    );

    always_comb begin
        sgn       = signed_mode & SIGNED_EN;
        dd_neg    = sgn & dd_in[N-1];
        dr_neg    = sgn & dr_in[N-1];
        dd_mag    = dd_neg ? -dd_in : dd_in;
        dr_mag    = dr_neg ? -dr_in : dr_in;
        accu_rest = accu_q + {1'b0, dr_mag_q};
        rem_mag   = accu_q[N] ? accu_rest[N-1:0] : accu_q[N-1:0];
    end

    always_comb begin
        state_d       = state_q;
        accu_d        = accu_q;
        dd_d          = dd_q;
        dr_mag_d      = dr_mag_q;
        cnt_d         = cnt_q;
        q_neg_d       = q_neg_q;
        r_neg_d       = r_neg_q;
        dbz_pend_d    = dbz_pend_q;
        ovf_pend_d    = ovf_pend_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        overflow_d    = overflow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d        = 1'b1;
                    div_by_zero_d = 1'b0;
                    overflow_d    = 1'b0;
                    q_neg_d       = dd_neg ^ dr_neg;
                    r_neg_d       = dd_neg;
                    dr_mag_d      = dr_mag;
                    cnt_d         = '0;
                    accu_d        = '0;
                    ovf_pend_d    = sgn & (dd_in == MIN_NEG) & (dr_in == {N{1'b1}});
                    // A zero divisor skips the iterations; the raw dividend is
                    // kept so it can be returned as the remainder.
                    if (dr_in == '0) begin
                        dbz_pend_d = 1'b1;
                        dd_d       = dd_in;
                        state_d    = FIN;
                    end else begin
                        dbz_pend_d = 1'b0;
                        dd_d       = dd_mag;
                        state_d    = CALC;
                    end
                end
            end
            CALC: begin
                accu_d = step_accu;
                dd_d   = {dd_q[N-2:0], step_qbit};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                accu_d  = {1'b0, (r_neg_q ? -rem_mag : rem_mag)};
                dd_d    = q_neg_q ? -dd_q : dd_q;
                state_d = FIN;
            end
            FIN: begin
                state_d       = IDLE;
                busy_d        = 1'b0;
                done_d        = 1'b1;
                quotient_d    = dbz_pend_q ? {N{1'b1}} : dd_q;
                remainder_d   = dbz_pend_q ? dd_q : accu_q[N-1:0];
                div_by_zero_d = dbz_pend_q;
                overflow_d    = ovf_pend_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            accu_q        <= '0;
            dd_q          <= '0;
            dr_mag_q      <= '0;
            cnt_q         <= '0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            dbz_pend_q    <= 1'b0;
            ovf_pend_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            accu_q        <= accu_d;
            dd_q          <= dd_d;
            dr_mag_q      <= dr_mag_d;
            cnt_q         <= cnt_d;
            q_neg_q       <= q_neg_d;
            r_neg_q       <= r_neg_d;
            dbz_pend_q    <= dbz_pend_d;
            ovf_pend_q    <= ovf_pend_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            overflow_q    <= overflow_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;
    assign overflow    = overflow_q;

endmodule
